md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//  Sequences the shared multiply/divide resource of the 5-stage MIPS pipeline (E stage).
//  Accepts one md op per issue and models its fixed multi-cycle latency.
//  Owns the HI/LO registers and raises the D-stage stall for md-class instructions while the unit is occupied.
//  Honours the exception flush, so an md op cancelled by an interrupt/exception never changes HI/LO.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu
//  DIV_CYCLES   10  busy cycles for div/divu
// PORTS
//  clk       in   1   single clock, rising edge
//  reset     in   1   synchronous, active-high
//  start     in   1   E-stage instr is an md op (mult/multu/div/divu/mthi/mtlo)
//  op        in   3   md opcode: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 ignored
//  rs_val    in   32  forwarded rs operand (E)
//  rt_val    in   32  forwarded rt operand (E)
//  flush     in   1   exception/interrupt taken this cycle; cancels this cycle's start
//  d_md      in   1   D-stage instr uses md unit (mult/div/mthi/mtlo/mfhi/mflo)
//  busy      out  1   multi-cycle op in flight
//  stall_md  out  1   stall request for F/D: d_md & (busy | start_mul_div)
//  hi        out  32  architectural HI (for mfhi in E)
//  lo        out  32  architectural LO (for mflo in E)
// BEHAVIOUR
//  Reset (clk edge with reset=1): cnt=0, busy=0, HI=0, LO=0, pending results=0. Reset mid-op
//    aborts the op; HI/LO read 0 next cycle.
//  accept = start & ~flush & ~busy & (op<=5). start with busy=1 is ignored: stall_md
//    already blocks this case, and the bench asserts it never occurs.
//  States: IDLE (cnt==0), BUSY (cnt!=0); busy = (cnt!=0), registered-derived, no comb path from start.
//  IDLE + accept, op MULT/MULTU/DIV/DIVU at edge T:
//    latch result: MULT {HI,LO}=$signed(rs)*$signed(rt) (64b); MULTU unsigned 64b;
//    DIV LO=signed quotient, HI=signed remainder (remainder takes dividend's sign, truncating);
//    DIVU unsigned quotient/remainder. Divisor==0: op still takes DIV_CYCLES, HI/LO unchanged.
//    cnt <= MULT_CYCLES or DIV_CYCLES -> busy=1 in cycles T+1..T+N.
//  BUSY: cnt decrements each edge; edge with cnt==1 commits pending to HI/LO, cnt->0.
//    New HI/LO visible (and busy=0) from cycle T+N+1.
//  IDLE + accept, op MTHI/MTLO: HI (or LO) <= rs_val at that edge; no busy.
//  flush=1: accept suppressed in same cycle; an op already in BUSY is NOT aborted (committed).
//  stall_md = d_md & (busy | (start & ~flush & op<=3)); so mfhi/mflo/md in D stalls
//    from the cycle mult/div sits in E until the cycle busy falls.
//  hi/lo: direct register outputs; never show partial/pending values.
//  Widths: all arithmetic full 64b product; quotient/remainder 32b; cnt width $clog2(max N+1).
//  Corner: DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
// STRUCTURE
//  Shared package/header: md op encodings (MD_MULT..MD_MTLO) for decode (ctrl) and this block.
//  One natural sub-module: md_alu (combinational mult/div result generator, 64b out);
//    sequencer keeps cnt, pending regs, HI/LO, stall logic.
// TESTING
//  1 reset: assert reset 2 cycles mid-DIV -> busy=0, hi=lo=0 next cycle, stall_md=0.
//  2 MULT rs=0xFFFFFFFE(-2), rt=3 at T -> busy T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  3 DIVU rs=100, rt=7 -> busy 10 cycles; afterwards lo=14, hi=2; DIV rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  4 MULT in E with mflo in D (d_md=1) -> stall_md=1 from T through T+5, drops at T+6 with new lo.
//  5 flush=1 with start=1 op=DIV -> busy stays 0, hi/lo unchanged; MTHI with flush -> HI unchanged.
//  6 MTLO rs=0x12345678 idle -> lo=0x12345678 next cycle, busy never set; DIV by 0 -> hi/lo unchanged after 10 cycles.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared md-unit definitions: opcode encodings used by decode and by the sequencer,
// plus the sequencer state type.
package md_sequencer_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_mul_div(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational multiply/divide result generator.
// result is {hi, lo}; div_zero flags a divide whose result must not be committed.
module md_alu
  import md_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, quo, rem;

  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000
  // instead of relying on simulator/host overflow behaviour.
  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    a_neg    = a[31];
    b_neg    = b[31];
    a_mag    = a_neg ? (~a + 32'd1) : a;
    b_mag    = b_neg ? (~b + 32'd1) : b;
    quo      = '0;
    rem      = '0;
    case (op)
      MD_MULT: begin
        result = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      end
      MD_MULTU: begin
        result = {32'd0, a} * {32'd0, b};
      end
      MD_DIV: begin
        div_zero = (b == 32'd0);
        if (!div_zero) begin
          quo    = a_mag / b_mag;
          rem    = a_mag % b_mag;
          result = {(a_neg ? (~rem + 32'd1) : rem),
                    ((a_neg ^ b_neg) ? (~quo + 32'd1) : quo)};
        end
      end
      MD_DIVU: begin
        div_zero = (b == 32'd0);
        if (!div_zero) begin
          quo    = a / b;
          rem    = a % b;
          result = {rem, quo};
        end
      end
      default: begin
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models fixed md latency
// and requests a D-stage stall while an md-class instruction would collide.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        d_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e        state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [31:0]      hi_q, hi_n, lo_q, lo_n;
  logic [63:0]      pend_q, pend_n;
  logic             pend_wr_q, pend_wr_n;
  logic [63:0]      alu_result;
  logic             alu_div_zero;
  logic             accept, start_mul_div;

  md_alu u_alu (
    .op       (op),
    .a        (rs_val),
    .b        (rt_val),
    .result   (alu_result),
    .div_zero (alu_div_zero)
  );

  assign busy          = (state_q == ST_BUSY);
  assign accept        = start & ~flush & ~busy & (op <= 3'd5);
  assign start_mul_div = start & ~flush & is_mul_div(op);
  assign stall_md      = d_md & (busy | start_mul_div);
  assign hi            = hi_q;
  assign lo            = lo_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      hi_q      <= hi_n;
      lo_q      <= lo_n;
      pend_q    <= pend_n;
      pend_wr_q <= pend_wr_n;
    end
  end

  // Results wait in pend until the last busy edge so HI/LO never show them early;
  // a zero-divisor divide still burns its cycles but leaves pend_wr clear.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    hi_n      = hi_q;
    lo_n      = lo_q;
    pend_n    = pend_q;
    pend_wr_n = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_mul_div(op)) begin
            pend_n    = alu_result;
            pend_wr_n = ~alu_div_zero;
            cnt_n     = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_n   = ST_BUSY;
          end else if (op == MD_MTHI) begin
            hi_n = rs_val;
          end else begin
            lo_n = rs_val;
          end
        end
      end
      ST_BUSY: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_n = ST_IDLE;
          if (pend_wr_q) begin
            hi_n = pend_q[63:32];
            lo_n = pend_q[31:0];
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed, self-checking bench for md_sequencer: a table of single md ops with
// hand-computed HI/LO and latency, plus reset, stall and flush sequences.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        d_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t vecs[12];

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .flush    (flush),
    .d_md     (d_md),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A new md op must never be presented while the unit is still busy.
  always @(negedge clk) begin
    if (!reset && start && !flush) begin
      checks++;
      if (busy) begin
        errors++;
        $display("[TB] FAIL start_while_busy: start=1 busy=%0b required busy=0", busy);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic f, input logic d);
    start  = s;
    op     = o;
    rs_val = a;
    rt_val = b;
    flush  = f;
    d_md   = d;
  endtask

  // Issue one op, then count busy cycles (bounded) and check the committed HI/LO.
  task automatic runVector(input int idx, input logic [31:0] prev_hi, input logic [31:0] prev_lo);
    int n;
    applyStimulus(1'b1, vecs[idx].op, vecs[idx].rs, vecs[idx].rt, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 0;
    while (busy && n < 50) begin
      if (n == 0) begin
        checkOutput($sformatf("v%0d_hi_held", idx), hi, prev_hi);
        checkOutput($sformatf("v%0d_lo_held", idx), lo, prev_lo);
      end
      n++;
      nextCycle();
    end
    checkOutput($sformatf("v%0d_cycles", idx), 32'(n), 32'(vecs[idx].cycles));
    checkOutput($sformatf("v%0d_hi", idx), hi, vecs[idx].exp_hi);
    checkOutput($sformatf("v%0d_lo", idx), lo, vecs[idx].exp_lo);
  endtask

  initial begin
    int n;
    logic [31:0] ph, pl;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        10};
    vecs[3]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[4]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[5]  = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[6]  = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    vecs[7]  = '{3'd2, 32'h1234_5678, 32'd0,         32'h3FFF_FFFF, 32'h0000_0001, 10};
    vecs[8]  = '{3'd5, 32'h1234_5678, 32'd0,         32'h3FFF_FFFF, 32'h1234_5678, 0};
    vecs[9]  = '{3'd4, 32'hCAFE_F00D, 32'd0,         32'hCAFE_F00D, 32'h1234_5678, 0};
    vecs[10] = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 10};
    vecs[11] = '{3'd6, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_000F, 32'h0FFF_FFFF, 0};

    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    d_md  = 1'b1;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_stall", 32'(stall_md), 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    d_md = 1'b0;
    nextCycle();

    for (int i = 0; i < 12; i++) begin
      ph = (i == 0) ? 32'd0 : vecs[i-1].exp_hi;
      pl = (i == 0) ? 32'd0 : vecs[i-1].exp_lo;
      runVector(i, ph, pl);
    end

    // MULT in E with mflo in D: stall from issue cycle until busy falls.
    applyStimulus(1'b1, 3'd0, 32'd2, 32'd5, 1'b0, 1'b1);
    #1;
    checkOutput("stall_issue", 32'(stall_md), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    #1;
    n = 0;
    while (stall_md && n < 50) begin
      n++;
      nextCycle();
      #1;
    end
    checkOutput("stall_cycles", 32'(n), 32'd5);
    checkOutput("stall_lo", lo, 32'd10);
    checkOutput("stall_hi", hi, 32'd0);
    d_md = 1'b0;

    // Flushed DIV: no stall, no busy, HI/LO untouched; flushed MTHI likewise.
    applyStimulus(1'b1, 3'd2, 32'd100, 32'd3, 1'b1, 1'b1);
    #1;
    checkOutput("flush_stall", 32'(stall_md), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 3'd4, 32'h5555_AAAA, 32'd0, 1'b1, 1'b0);
    checkOutput("flush_busy", 32'(busy), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("flush_hi", hi, 32'd0);
    checkOutput("flush_lo", lo, 32'd10);

    // A flush arriving while a MULT is in flight must not abort it.
    applyStimulus(1'b1, 3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    nextCycle();
    flush = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      nextCycle();
    end
    checkOutput("flush_inflight_lo", lo, 32'd42);

    // Reset held two cycles in the middle of a DIVU aborts it completely.
    applyStimulus(1'b1, 3'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    nextCycle();
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_hi", hi, 32'd0);
    checkOutput("midrst_lo", lo, 32'd0);
    nextCycle();
    reset = 1'b0;
    d_md  = 1'b1;
    #1;
    checkOutput("midrst_stall", 32'(stall_md), 32'd0);
    for (int k = 0; k < 12; k++) nextCycle();
    checkOutput("midrst_late_busy", 32'(busy), 32'd0);
    checkOutput("midrst_late_lo", lo, 32'd0);
    d_md = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
